// File: rtl/mcu_spi_slave_if.sv
// mcu_spi_slave_if: SPI pins plus the decoder-side
// byte bus of the MCU SPI slave front end.
interface mcu_spi_slave_if;
  logic        spi_sck;
  logic        spi_ssel_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [7:0]  spi_data_in;
  logic        cmd_ready;
  logic        param_ready;
  logic [7:0]  cmd_data;
  logic [7:0]  param_data;
  logic [31:0] spi_byte_cnt;
  logic [2:0]  spi_bit_cnt;

  modport slave (
    input  spi_sck,
    input  spi_ssel_n,
    input  spi_mosi,
    input  spi_data_in,
    output spi_miso,
    output spi_miso_oe,
    output cmd_ready,
    output param_ready,
    output cmd_data,
    output param_data,
    output spi_byte_cnt,
    output spi_bit_cnt
  );

  modport master (
    output spi_sck,
    output spi_ssel_n,
    output spi_mosi,
    output spi_data_in,
    input  spi_miso,
    input  spi_miso_oe,
    input  cmd_ready,
    input  param_ready,
    input  cmd_data,
    input  param_data,
    input  spi_byte_cnt,
    input  spi_bit_cnt
  );
endinterface

// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: oversampled SPI mode-0 slave that splits
// MOSI into command/parameter bytes and shifts replies out.
module mcu_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst_n,
  mcu_spi_slave_if.slave bus
);
  localparam int S = SYNC_STAGES;

  logic [S:0]   sck_q;
  logic [S-1:0] ssel_q;
  logic [S-1:0] mosi_q;
  logic         rise;
  logic         fall;
  logic         ssel_hi;
  logic         active;
  logic         armed;
  logic         done;
  logic         miso_q;
  logic         cmd_rdy;
  logic         par_rdy;
  logic [7:0]   rx;
  logic [7:0]   tx;
  logic [7:0]   cmd_q;
  logic [7:0]   par_q;
  logic [31:0]  byte_cnt;
  logic [2:0]   bit_cnt;

  assign rise    = sck_q[S-1] & ~sck_q[S];
  assign fall    = ~sck_q[S-1] & sck_q[S];
  assign ssel_hi = ssel_q[S-1];
  assign active  = armed & ~ssel_hi;

  // Pin synchronisers; SCK carries one extra history flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_q  <= '0;
      ssel_q <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[S-1:0], bus.spi_sck};
      ssel_q <= {ssel_q[S-2:0], bus.spi_ssel_n};
      mosi_q <= {mosi_q[S-2:0], bus.spi_mosi};
    end
  end

  // Receive/transmit shifting, byte completion and strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      done     <= 1'b0;
      miso_q   <= 1'b0;
      cmd_rdy  <= 1'b0;
      par_rdy  <= 1'b0;
      rx       <= '0;
      tx       <= '0;
      cmd_q    <= '0;
      par_q    <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      cmd_rdy <= 1'b0;
      par_rdy <= 1'b0;
      miso_q  <= tx[7];
      if (ssel_hi) armed <= 1'b1;
      if (!active) begin
        done     <= 1'b0;
        rx       <= '0;
        tx       <= '0;
        byte_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (done) begin
          done <= 1'b0;
          if (byte_cnt == 32'd0) begin
            cmd_rdy <= 1'b1;
            cmd_q   <= rx;
          end else begin
            par_rdy <= 1'b1;
            par_q   <= rx;
          end
          if (byte_cnt != '1)
            byte_cnt <= byte_cnt + 32'd1;
        end
        if (rise) begin
          rx      <= {rx[6:0], mosi_q[S-1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) done <= 1'b1;
        end
        if (fall) begin
          if (bit_cnt == 3'd0) tx <= bus.spi_data_in;
          else tx <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_miso     = miso_q;
  assign bus.spi_miso_oe  = active;
  assign bus.cmd_ready    = cmd_rdy;
  assign bus.param_ready  = par_rdy;
  assign bus.cmd_data     = cmd_q;
  assign bus.param_data   = par_q;
  assign bus.spi_byte_cnt = byte_cnt;
  assign bus.spi_bit_cnt  = bit_cnt;
endmodule

// File: tb/tb_mcu_spi_slave.sv
// tb_mcu_spi_slave: directed and random SPI transactions
// checked against a byte-level transaction model.
module tb_mcu_spi_slave;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        is_cmd;
    logic [7:0]  data;
    logic [31:0] cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  ev_t  evq[$];
  logic prev_c = 1'b0;
  logic prev_p = 1'b0;
  bq_t  mo;
  bq_t  rsp;
  logic [7:0] g;

  mcu_spi_slave_if bus();

  mcu_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(
      input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Strobe monitor: records every strobe and checks its shape.
  always @(negedge clk) begin
    if (bus.cmd_ready === 1'b1 || bus.param_ready === 1'b1) begin
      ev_t e;
      total++;
      assert (!(bus.cmd_ready && bus.param_ready) &&
              !(bus.cmd_ready && prev_c === 1'b1) &&
              !(bus.param_ready && prev_p === 1'b1)) else begin
        bad++;
        $error("FAIL strobe_shape: cmd=%0b param=%0b prev=%0b%0b expected one 1-clk strobe",
               bus.cmd_ready, bus.param_ready, prev_c, prev_p);
      end
      e.is_cmd = bus.cmd_ready;
      e.data = bus.cmd_ready ? bus.cmd_data : bus.param_data;
      e.cnt = bus.spi_byte_cnt;
      evq.push_back(e);
    end
    prev_c <= bus.cmd_ready;
    prev_p <= bus.param_ready;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel();
    bus.spi_ssel_n = 1'b0;
    wclk(8);
  endtask

  task automatic desel();
    wclk(6);
    bus.spi_ssel_n = 1'b1;
    wclk(8);
  endtask

  // Master side of one byte; reply is presented mid-byte.
  task automatic xfer(input logic [7:0] b,
                      input logic [7:0] r,
                      input int nbits,
                      input logic drop,
                      output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == 1) bus.spi_data_in = r;
      bus.spi_mosi = b[7-i];
      wclk(6);
      if (drop && i == nbits - 1) bus.spi_ssel_n = 1'b1;
      got[7-i] = bus.spi_miso;
      bus.spi_sck = 1'b1;
      wclk(6);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " byte_cnt"}, bus.spi_byte_cnt, 32'd0);
    check({tag, " bit_cnt"}, 32'(bus.spi_bit_cnt), 32'd0);
    check({tag, " oe"}, 32'(bus.spi_miso_oe), 32'd0);
  endtask

  // Full transaction checked against the byte-level model.
  task automatic run_txn(input string tag,
                         input bq_t mo_i,
                         input bq_t rsp_i);
    bq_t got;
    logic [7:0] gb;
    logic [7:0] want;
    logic [31:0] cnt;
    int n;
    evq.delete();
    sel();
    foreach (mo_i[i]) begin
      xfer(mo_i[i], rsp_i[i], 8, 1'b0, gb);
      got.push_back(gb);
    end
    desel();
    n = mo_i.size();
    check({tag, " nev"}, 32'(evq.size()), 32'(n));
    cnt = 32'd0;
    for (int i = 0; i < n; i++) begin
      cnt = sat_inc(cnt);
      if (i < evq.size()) begin
        check($sformatf("%s ev%0d kind", tag, i),
              32'(evq[i].is_cmd), 32'(i == 0));
        check($sformatf("%s ev%0d data", tag, i),
              32'(evq[i].data), 32'(mo_i[i]));
        check($sformatf("%s ev%0d cnt", tag, i),
              evq[i].cnt, cnt);
      end
      if (i == 0) want = 8'h00;
      else want = rsp_i[i-1];
      check($sformatf("%s miso%0d", tag, i),
            32'(got[i]), 32'(want));
    end
    check_idle(tag);
    check({tag, " cmd_hold"}, 32'(bus.cmd_data),
          32'(mo_i[0]));
    if (n > 1)
      check({tag, " par_hold"}, 32'(bus.param_data),
            32'(mo_i[n-1]));
  endtask

  initial begin
    bus.spi_sck = 1'b0;
    bus.spi_ssel_n = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_data_in = 8'h00;

    // reset held 3 clk while SCK toggles
    repeat (3) begin
      @(negedge clk);
      bus.spi_sck = ~bus.spi_sck;
    end
    check("rst miso", 32'(bus.spi_miso), 32'd0);
    check("rst oe", 32'(bus.spi_miso_oe), 32'd0);
    check("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst param_ready", 32'(bus.param_ready), 32'd0);
    check("rst cmd_data", 32'(bus.cmd_data), 32'd0);
    check("rst param_data", 32'(bus.param_data), 32'd0);
    check("rst byte_cnt", bus.spi_byte_cnt, 32'd0);
    check("rst bit_cnt", 32'(bus.spi_bit_cnt), 32'd0);

    // SSEL already low at release: not armed yet
    bus.spi_sck = 1'b0;
    rst_n = 1'b1;
    evq.delete();
    xfer(8'hC3, 8'h00, 8, 1'b0, g);
    xfer(8'h3C, 8'h00, 8, 1'b0, g);
    wclk(6);
    check("noarm nev", 32'(evq.size()), 32'd0);
    check_idle("noarm");
    bus.spi_ssel_n = 1'b1;
    wclk(8);

    mo = {};
    rsp = {};
    mo.push_back(8'hF0);
    mo.push_back(8'h00);
    rsp.push_back(8'hA5);
    rsp.push_back(8'hA5);
    run_txn("f0_00", mo, rsp);

    mo = {};
    rsp = {};
    mo.push_back(8'h10);
    mo.push_back(8'h12);
    mo.push_back(8'h34);
    mo.push_back(8'h56);
    rsp.push_back(8'h81);
    rsp.push_back(8'h7E);
    rsp.push_back(8'hC9);
    rsp.push_back(8'h00);
    run_txn("four", mo, rsp);

    // abort after 5 bits of the second byte
    evq.delete();
    sel();
    xfer(8'h33, 8'h00, 8, 1'b0, g);
    xfer(8'hC7, 8'h00, 5, 1'b0, g);
    desel();
    check("abort nev", 32'(evq.size()), 32'd1);
    check_idle("abort");
    check("abort par_hold", 32'(bus.param_data), 32'h56);
    mo = {};
    rsp = {};
    mo.push_back(8'h20);
    rsp.push_back(8'h00);
    run_txn("after_abort", mo, rsp);

    // byte count saturation via override
    evq.delete();
    sel();
    xfer(8'h5A, 8'h00, 8, 1'b0, g);
    force dut.byte_cnt = 32'hFFFF_FFFE;
    wclk(1);
    release dut.byte_cnt;
    xfer(8'hB1, 8'h00, 8, 1'b0, g);
    xfer(8'hB2, 8'h00, 8, 1'b0, g);
    wclk(2);
    check("sat nev", 32'(evq.size()), 32'd3);
    if (evq.size() == 3) begin
      check("sat ev1 kind", 32'(evq[1].is_cmd), 32'd0);
      check("sat ev1 cnt", evq[1].cnt,
            sat_inc(32'hFFFF_FFFE));
      check("sat ev2 data", 32'(evq[2].data), 32'hB2);
      check("sat ev2 cnt", evq[2].cnt,
            sat_inc(sat_inc(32'hFFFF_FFFE)));
    end
    check("sat end cnt", bus.spi_byte_cnt, 32'hFFFF_FFFF);
    desel();
    check_idle("sat");

    // SSEL rises together with the 8th-bit SCK rise
    evq.delete();
    sel();
    xfer(8'h81, 8'h00, 8, 1'b0, g);
    xfer(8'h7E, 8'h00, 8, 1'b1, g);
    check("clash nev", 32'(evq.size()), 32'd1);
    check_idle("clash");
    wclk(8);

    // reset mid-transaction, SSEL kept low afterwards
    evq.delete();
    sel();
    xfer(8'hAA, 8'h00, 3, 1'b0, g);
    rst_n = 1'b0;
    wclk(1);
    rst_n = 1'b1;
    check("mrst cmd_data", 32'(bus.cmd_data), 32'd0);
    xfer(8'h55, 8'h00, 8, 1'b0, g);
    xfer(8'h66, 8'h00, 8, 1'b0, g);
    wclk(6);
    check("mrst nev", 32'(evq.size()), 32'd0);
    check_idle("mrst");
    desel();

    // random transactions
    for (int t = 0; t < 5; t++) begin
      int len;
      len = int'($urandom_range(1, 5));
      mo = {};
      rsp = {};
      for (int k = 0; k < len; k++) begin
        mo.push_back(8'($urandom));
        rsp.push_back(8'($urandom));
      end
      run_txn($sformatf("rnd%0d", t), mo, rsp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
